// File: rtl/pulse_profile_sequencer.sv
// Rate scheduler for the variable pulse generator.
// Modes 0-2 select a fixed half-period. Mode 3 plays a 12-segment timed
// profile that is advanced by a 1 Hz strobe. All outputs are registered.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst          synchronous active-high reset
//   start        run request; low forces idle
//   mode         rate select; 3 selects the profile
//   tick_1hz     one-cycle strobe, once per second
//   half_period  divide value for the pulse generator; 0 means no pulses
//   pulse_en     high while the pulse generator must toggle
//   cfg_upd      one-cycle strobe in the cycle half_period takes a new value
//   seg_idx      current profile segment, 0-11
//   elapsed_s    seconds elapsed in the profile, saturating at 144
//   profile_done high once the profile has completed
module pulse_profile_sequencer #(
  parameter int unsigned FIX0_HP = 1562500,
  parameter int unsigned FIX1_HP = 781250,
  parameter int unsigned FIX2_HP = 390625,
  parameter int unsigned HP_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic            tick_1hz,
  output logic [HP_W-1:0] half_period,
  output logic            pulse_en,
  output logic            cfg_upd,
  output logic [3:0]      seg_idx,
  output logic [7:0]      elapsed_s,
  output logic            profile_done
);

  typedef enum logic [1:0] {StIdle, StFixed, StRun, StDone} state_e;

  localparam logic [3:0] LastSeg    = 4'd11;
  localparam logic [7:0] ElapsedMax = 8'd144;

  state_e          state_q, state_d;
  logic [6:0]      sec_cnt_q, sec_cnt_d;
  logic [HP_W-1:0] hp_d;
  logic            pe_d, done_d;
  logic [3:0]      seg_d;
  logic [7:0]      el_d;

  logic go_idle, go_fixed, go_run, go_done, seg_adv;

  // Profile half-periods.
  function automatic logic [HP_W-1:0] rom_hp(input logic [3:0] idx);
    logic [31:0] v;
    case (idx)
      4'd0:    v = 32'd2500000;
      4'd1:    v = 32'd1562500;
      4'd2:    v = 32'd757575;
      4'd3:    v = 32'd1923076;
      4'd4:    v = 32'd714285;
      4'd5:    v = 32'd1666666;
      4'd6:    v = 32'd2500000;
      4'd7:    v = 32'd1666666;
      4'd8:    v = 32'd1562500;
      4'd9:    v = 32'd714285;
      4'd10:   v = 32'd1470588;
      4'd11:   v = 32'd403225;
      default: v = 32'd0;
    endcase
    return HP_W'(v);
  endfunction

  // Profile segment durations in seconds.
  function automatic logic [6:0] rom_dur(input logic [3:0] idx);
    case (idx)
      4'd9:    return 7'd65;
      4'd10:   return 7'd6;
      4'd11:   return 7'd64;
      default: return 7'd1;
    endcase
  endfunction

  function automatic logic [HP_W-1:0] fixed_hp(input logic [1:0] m);
    case (m)
      2'd1:    return HP_W'(FIX1_HP);
      2'd2:    return HP_W'(FIX2_HP);
      default: return HP_W'(FIX0_HP);
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    hp_d      = half_period;
    pe_d      = pulse_en;
    done_d    = profile_done;
    seg_d     = seg_idx;
    el_d      = elapsed_s;
    go_idle   = 1'b0;
    go_fixed  = 1'b0;
    go_run    = 1'b0;
    go_done   = 1'b0;
    seg_adv   = 1'b0;

    // State changes take priority over the tick, so a tick coinciding with
    // a start/mode change (or with entry into the profile) is dropped.
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (mode == 2'd3) go_run = 1'b1;
          else              go_fixed = 1'b1;
        end
      end
      StFixed: begin
        if (!start)             go_idle = 1'b1;
        else if (mode == 2'd3)  go_run = 1'b1;
        else                    go_fixed = 1'b1; // track mode changes among 0-2
      end
      StRun: begin
        if (!start)             go_idle = 1'b1;
        else if (mode != 2'd3)  go_fixed = 1'b1;
        else if (tick_1hz) begin
          el_d = (elapsed_s == ElapsedMax) ? elapsed_s : elapsed_s + 8'd1;
          if (sec_cnt_q + 7'd1 == rom_dur(seg_idx)) begin
            if (seg_idx == LastSeg) go_done = 1'b1;
            else                    seg_adv = 1'b1;
          end else begin
            sec_cnt_d = sec_cnt_q + 7'd1;
          end
        end
      end
      StDone: begin
        if (!start)             go_idle = 1'b1;
        else if (mode != 2'd3)  go_fixed = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    // Leaving the profile for idle/fixed discards all progress.
    if (go_idle) begin
      state_d   = StIdle;
      hp_d      = '0;
      pe_d      = 1'b0;
      done_d    = 1'b0;
      seg_d     = '0;
      el_d      = '0;
      sec_cnt_d = '0;
    end else if (go_fixed) begin
      state_d   = StFixed;
      hp_d      = fixed_hp(mode);
      pe_d      = 1'b1;
      done_d    = 1'b0;
      seg_d     = '0;
      el_d      = '0;
      sec_cnt_d = '0;
    end else if (go_run) begin
      state_d   = StRun;
      hp_d      = rom_hp(4'd0);
      pe_d      = 1'b1;
      done_d    = 1'b0;
      seg_d     = '0;
      el_d      = '0;
      sec_cnt_d = '0;
    end else if (go_done) begin
      state_d   = StDone;
      hp_d      = '0;
      pe_d      = 1'b0;
      done_d    = 1'b1;
      sec_cnt_d = '0;
    end else if (seg_adv) begin
      seg_d     = seg_idx + 4'd1;
      hp_d      = rom_hp(seg_idx + 4'd1);
      sec_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sec_cnt_q    <= '0;
      half_period  <= '0;
      pulse_en     <= 1'b0;
      cfg_upd      <= 1'b0;
      seg_idx      <= '0;
      elapsed_s    <= '0;
      profile_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_cnt_q    <= sec_cnt_d;
      half_period  <= hp_d;
      pulse_en     <= pe_d;
      cfg_upd      <= (hp_d != half_period);
      seg_idx      <= seg_d;
      elapsed_s    <= el_d;
      profile_done <= done_d;
    end
  end

endmodule

// File: tb/tb_pulse_profile_sequencer.sv
// Self-checking bench for pulse_profile_sequencer: a cycle-by-cycle vector
// table for reset, fixed modes and profile entry, then hand-written sequences
// for the full 144 s profile, mid-profile abort and restart after done.
module tb_pulse_profile_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        tick_1hz;
  logic [31:0] half_period;
  logic        pulse_en;
  logic        cfg_upd;
  logic [3:0]  seg_idx;
  logic [7:0]  elapsed_s;
  logic        profile_done;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_profile_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .tick_1hz     (tick_1hz),
    .half_period  (half_period),
    .pulse_en     (pulse_en),
    .cfg_upd      (cfg_upd),
    .seg_idx      (seg_idx),
    .elapsed_s    (elapsed_s),
    .profile_done (profile_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        tick;
    logic [31:0] hp;
    logic        pe;
    logic        cu;
    logic        prof;  // compare seg_idx/elapsed_s in this row
    logic [3:0]  seg;
    logic [7:0]  el;
    logic        done;
  } vec_t;

  localparam int NumVec = 19;
  vec_t vecs [NumVec];

  logic [31:0] exp_hp [12];

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] m, input logic t,
                              input logic [31:0] hp, input logic pe, input logic cu,
                              input logic prof, input logic [3:0] seg, input logic [7:0] el,
                              input logic done);
    vec_t v;
    v.rst = r; v.start = s; v.mode = m; v.tick = t;
    v.hp = hp; v.pe = pe; v.cu = cu; v.prof = prof; v.seg = seg; v.el = el; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Tick in one cycle; outputs after the call reflect that tick.
  task automatic do_tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic chk_prof(input string name, input logic [31:0] hp, input logic pe,
                          input logic cu, input logic [3:0] seg, input logic [7:0] el,
                          input logic done);
    chk({name, ".half_period"}, half_period, hp);
    chk({name, ".pulse_en"}, 32'(pulse_en), 32'(pe));
    chk({name, ".cfg_upd"}, 32'(cfg_upd), 32'(cu));
    chk({name, ".seg_idx"}, 32'(seg_idx), 32'(seg));
    chk({name, ".elapsed_s"}, 32'(elapsed_s), 32'(el));
    chk({name, ".profile_done"}, 32'(profile_done), 32'(done));
  endtask

  initial begin
    exp_hp = '{32'd2500000, 32'd1562500, 32'd757575, 32'd1923076, 32'd714285, 32'd1666666,
               32'd2500000, 32'd1666666, 32'd1562500, 32'd714285, 32'd1470588, 32'd403225};

    //               rst  st   mode  tick hp          pe   cu   prof seg  el   done
    vecs[0]  = mk(1'b1, 1'b1, 2'd3, 1'b0, 32'd0,       1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 2'd3, 1'b0, 32'd0,       1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 2'd3, 1'b0, 32'd0,       1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 2'd3, 1'b0, 32'd2500000, 1'b1, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 2'd3, 1'b0, 32'd2500000, 1'b1, 1'b0, 1'b1, 4'd0, 8'd0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 2'd1, 1'b0, 32'd781250,  1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 2'd1, 1'b0, 32'd781250,  1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'd390625,  1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 2'd2, 1'b0, 32'd390625,  1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 2'd2, 1'b0, 32'd0,       1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 2'd2, 1'b0, 32'd0,       1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 2'd0, 1'b0, 32'd1562500, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
    vecs[12] = mk(1'b0, 1'b1, 2'd0, 1'b1, 32'd1562500, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    // Entry into the profile with a coincident tick: the tick is dropped.
    vecs[13] = mk(1'b0, 1'b1, 2'd3, 1'b1, 32'd2500000, 1'b1, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 2'd3, 1'b0, 32'd2500000, 1'b1, 1'b0, 1'b1, 4'd0, 8'd0, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 2'd3, 1'b1, 32'd1562500, 1'b1, 1'b1, 1'b1, 4'd1, 8'd1, 1'b0);
    vecs[16] = mk(1'b0, 1'b1, 2'd3, 1'b0, 32'd1562500, 1'b1, 1'b0, 1'b1, 4'd1, 8'd1, 1'b0);
    // Segment 1 -> fixed mode 0: same value, so no cfg_upd.
    vecs[17] = mk(1'b0, 1'b1, 2'd0, 1'b0, 32'd1562500, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    vecs[18] = mk(1'b0, 1'b1, 2'd3, 1'b0, 32'd2500000, 1'b1, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0);

    rst = 1'b1; start = 1'b1; mode = 2'd3; tick_1hz = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; mode = vecs[i].mode; tick_1hz = vecs[i].tick;
      cyc();
      chk($sformatf("vec%0d.half_period", i), half_period, vecs[i].hp);
      chk($sformatf("vec%0d.pulse_en", i), 32'(pulse_en), 32'(vecs[i].pe));
      chk($sformatf("vec%0d.cfg_upd", i), 32'(cfg_upd), 32'(vecs[i].cu));
      chk($sformatf("vec%0d.profile_done", i), 32'(profile_done), 32'(vecs[i].done));
      if (vecs[i].prof) begin
        chk($sformatf("vec%0d.seg_idx", i), 32'(seg_idx), 32'(vecs[i].seg));
        chk($sformatf("vec%0d.elapsed_s", i), 32'(elapsed_s), 32'(vecs[i].el));
      end
    end
    tick_1hz = 1'b0;
    cyc();

    // Full profile from segment 0.
    for (int i = 1; i <= 9; i++) begin
      do_tick();
      chk_prof($sformatf("seg%0d", i), exp_hp[i], 1'b1, 1'b1, 4'(i), 8'(i), 1'b0);
      cyc();
      chk($sformatf("seg%0d.cfg_upd_clear", i), 32'(cfg_upd), 32'd0);
    end
    for (int i = 0; i < 64; i++) begin
      do_tick();
      cyc();
    end
    chk_prof("seg9_end", 32'd714285, 1'b1, 1'b0, 4'd9, 8'd73, 1'b0);
    do_tick();
    chk_prof("seg10", 32'd1470588, 1'b1, 1'b1, 4'd10, 8'd74, 1'b0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      do_tick();
      cyc();
    end
    chk_prof("seg10_end", 32'd1470588, 1'b1, 1'b0, 4'd10, 8'd79, 1'b0);
    do_tick();
    chk_prof("seg11", 32'd403225, 1'b1, 1'b1, 4'd11, 8'd80, 1'b0);
    cyc();
    for (int i = 0; i < 63; i++) begin
      do_tick();
      cyc();
    end
    chk_prof("seg11_end", 32'd403225, 1'b1, 1'b0, 4'd11, 8'd143, 1'b0);
    do_tick();
    chk_prof("done", 32'd0, 1'b0, 1'b1, 4'd11, 8'd144, 1'b1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      do_tick();
      cyc();
    end
    chk_prof("done_hold", 32'd0, 1'b0, 1'b0, 4'd11, 8'd144, 1'b1);

    // Leave done via start=0, then restart the profile.
    start = 1'b0;
    cyc();
    chk("done_exit.profile_done", 32'(profile_done), 32'd0);
    chk("done_exit.pulse_en", 32'(pulse_en), 32'd0);
    chk("done_exit.half_period", half_period, 32'd0);
    chk("done_exit.cfg_upd", 32'(cfg_upd), 32'd0);
    start = 1'b1; mode = 2'd3;
    cyc();
    chk_prof("restart", 32'd2500000, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0);
    cyc();

    // Mid-profile abort to fixed mode 0 with a coincident tick.
    for (int i = 0; i < 9; i++) begin
      do_tick();
      cyc();
    end
    chk_prof("abort_pre", 32'd714285, 1'b1, 1'b0, 4'd9, 8'd9, 1'b0);
    mode = 2'd0; tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    chk("abort.half_period", half_period, 32'd1562500);
    chk("abort.cfg_upd", 32'(cfg_upd), 32'd1);
    chk("abort.pulse_en", 32'(pulse_en), 32'd1);
    cyc();
    mode = 2'd3;
    cyc();
    chk_prof("reenter", 32'd2500000, 1'b1, 1'b1, 4'd0, 8'd0, 1'b0);
    cyc();
    do_tick();
    chk_prof("reenter_tick", 32'd1562500, 1'b1, 1'b1, 4'd1, 8'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_profile_sequencer.md
Name: pulse_profile_sequencer

Overview:
Scheduler that drives the half-period (divide) input of the variable pulse generator on the 100 MHz system clock. Modes 0-2 select a fixed rate. Mode 3 steps through a 12-segment timed rate profile, advanced by a 1 Hz tick strobe. The block outputs the active half-period, a pulse enable, a profile position and a done flag to the pulse generator and the display logic.

Parameters:
FIX0_HP, 1562500, half-period for mode 0 (32 Hz)
FIX1_HP, 781250, half-period for mode 1 (64 Hz)
FIX2_HP, 390625, half-period for mode 2 (128 Hz)
HP_W, 32, width of the half-period value

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
start  in  1  run request; low forces IDLE
mode  in  2  rate select; 3 = profile
tick_1hz  in  1  one-clk-cycle strobe, once per second
half_period  out  HP_W  divide value for the pulse generator; 0 = no pulses
pulse_en  out  1  high while the pulse generator must toggle
cfg_upd  out  1  one-cycle strobe when half_period changes value
seg_idx  out  4  current profile segment, 0-11
elapsed_s  out  8  seconds elapsed in profile, saturates at 144
profile_done  out  1  high in DONE

Behaviour:
- One clock domain. Reset is synchronous and active-high; rst wins over all other inputs.
- Reset values: half_period=0, pulse_en=0, cfg_upd=0, seg_idx=0, elapsed_s=0, profile_done=0, state=IDLE.
- Profile ROM, 12 entries of half-period and duration in seconds:
  - Segments 0-8 are 1 s each, in order 20, 32, 66, 26, 70, 30, 20, 30, 32 Hz. Half-periods: 2500000, 1562500, 757575, 1923076, 714285, 1666666, 2500000, 1666666, 1562500.
  - Segment 9: 714285 for 65 s.
  - Segment 10: 1470588 for 6 s.
  - Segment 11: 403225 for 64 s.
  - Total 144 s.
- States are IDLE, FIXED, RUN, DONE. Transitions are evaluated every cycle; all outputs are registered (1-cycle latency from inputs).
  - IDLE: half_period=0, pulse_en=0.
    - start=1 and mode<3 -> FIXED.
    - start=1 and mode=3 -> RUN with seg_idx=0, sec_cnt=0, elapsed_s=0.
  - FIXED: half_period=FIXn_HP for the current mode, pulse_en=1.
    - A mode change among 0-2 updates half_period on the next cycle.
    - mode=3 -> RUN from segment 0.
    - start=0 -> IDLE.
  - RUN: half_period=ROM[seg_idx], pulse_en=1.
    - On tick_1hz: elapsed_s++ (saturating at 144) and sec_cnt++.
    - If sec_cnt+1 == dur[seg_idx]: sec_cnt=0 and seg_idx++.
    - If seg_idx was 11, go to DONE instead.
    - mode<3 -> FIXED, and profile progress is discarded. Re-entering mode 3 always restarts at segment 0.
    - start=0 -> IDLE.
  - DONE: half_period=0, pulse_en=0, profile_done=1, seg_idx holds 11, elapsed_s holds 144.
    - Exits only via start=0 (-> IDLE) or mode<3 (-> FIXED).
- Simultaneous events:
  - start/mode change in the same cycle as tick_1hz: the state change wins and the tick is ignored.
  - The tick in the cycle of entry into RUN is ignored; the first counted tick is the next one.
- cfg_upd pulses for exactly one cycle, the cycle in which half_period takes its new value. It pulses on any change, including to or from 0. It does not pulse when the value is unchanged, e.g. segment 1 -> FIXED mode 0 (both 1562500).
- sec_cnt is internal, 7 bits; durations are at most 65.
- Advance is purely tick-driven, with no dependence on the clk count between ticks. Ticks are assumed to be at least 2 cycles apart.

Test Plan:
- rst=1 for 3 cycles with start=1, mode=3 -> all outputs at reset values; 1 cycle after release: state RUN, half_period=2500000, cfg_upd=1 for one cycle.
- start=1, mode=1 -> half_period=781250 and pulse_en=1 one cycle later; switch mode to 2 -> 390625 next cycle with a cfg_upd pulse; start=0 -> half_period=0, pulse_en=0.
- mode=3, issue 9 ticks -> seg_idx sequence 1..9, half_period sequence 1562500, 757575, 1923076, 714285, 1666666, 2500000, 1666666, 1562500, 714285. The segment 4->5->...->9 changes each pulse cfg_upd, except segments 8->9 are 1562500->714285 (pulses).
- Continue with 65 more ticks -> seg_idx=10, half_period=1470588 at elapsed_s=74; 6 ticks -> seg_idx=11, 403225 at 80; 64 ticks -> DONE, half_period=0, profile_done=1, elapsed_s=144; extra ticks -> no change.
- Mid-profile at seg_idx=9, set mode=0 in the same cycle as a tick -> FIXED, 1562500, tick ignored; return to mode=3 -> seg_idx=0, elapsed_s=0, half_period=2500000.
- In DONE, drop start -> IDLE, profile_done=0; raise start with mode=3 -> profile restarts at segment 0.
